// File: rtl/estado_mascota_if.sv
// Pet-state bus: need levels and action indicators in, display state and status out.
interface estado_mascota_if;
    logic       test;
    logic [1:0] Nivel_Animo;
    logic [1:0] Nivel_Energia;
    logic [1:0] Nivel_Descanso;
    logic [1:0] Nivel_Medicina;
    logic       senal_5segEnergia;
    logic       senal_5segMedicina;
    logic [2:0] estado;
    logic       alarma;
    logic       muerto;
    logic       modo_test;
    logic [7:0] edad;
    logic       tick_seg;

    modport master (
        output test, Nivel_Animo, Nivel_Energia, Nivel_Descanso, Nivel_Medicina,
               senal_5segEnergia, senal_5segMedicina,
        input  estado, alarma, muerto, modo_test, edad, tick_seg
    );

    modport slave (
        input  test, Nivel_Animo, Nivel_Energia, Nivel_Descanso, Nivel_Medicina,
               senal_5segEnergia, senal_5segMedicina,
        output estado, alarma, muerto, modo_test, edad, tick_seg
    );
endinterface

// File: rtl/estado_mascota.sv
// Pet global state: seconds prescaler with test acceleration, action animations,
// critical-need death timer, age counter and prioritised display state.
//
// state      | meaning
// NORMAL     | all needs satisfied
// TRISTE     | Animo critical
// HAMBRIENTO | Energia critical
// CANSADO    | Descanso critical
// ENFERMO    | Medicina critical
// COMIENDO   | feeding animation running
// CURANDO    | medicine animation running
// MUERTO     | pet dead, frozen until reset
module estado_mascota #(
    parameter int TICKS_SEG = 50_000_000,
    parameter int TEST_DIV  = 10,
    parameter int T_MUERTE  = 30,
    parameter int T_ANIM    = 3
) (
    input  logic             clk,
    input  logic             reset,
    estado_mascota_if.slave  bus
);

    typedef enum logic [2:0] {
        NORMAL     = 3'd0,
        TRISTE     = 3'd1,
        HAMBRIENTO = 3'd2,
        CANSADO    = 3'd3,
        ENFERMO    = 3'd4,
        COMIENDO   = 3'd5,
        CURANDO    = 3'd6,
        MUERTO     = 3'd7
    } state_t;

    localparam int              CW        = $clog2(TICKS_SEG + 1);
    localparam logic [CW-1:0]   LAST_NORM = CW'(TICKS_SEG - 1);
    localparam logic [CW-1:0]   LAST_TEST = CW'(TICKS_SEG / TEST_DIV - 1);
    localparam logic [3:0]      ANIM_LOAD = 4'(T_ANIM);
    localparam logic [7:0]      MUERTE_CNT = 8'(T_MUERTE);

    logic [CW-1:0] pre_cnt;
    logic          modo_q;
    logic          tick;

    logic          e_prev;
    logic          m_prev;
    logic          rise_e;
    logic          rise_m;
    logic [3:0]    anim_cnt;
    state_t        anim_tipo;

    logic          crit;
    logic [7:0]    crit_cnt;
    logic          muerto_q;
    logic          alarma_q;
    logic [7:0]    edad_q;
    state_t        estado_q;
    state_t        estado_d;

    // A test pulse restarts the second, so it also suppresses a coincident tick.
    assign tick   = (pre_cnt == (modo_q ? LAST_TEST : LAST_NORM)) && !bus.test;
    assign rise_e = bus.senal_5segEnergia && !e_prev;
    assign rise_m = bus.senal_5segMedicina && !m_prev;
    assign crit   = (bus.Nivel_Animo == 2'd0) || (bus.Nivel_Energia == 2'd0) ||
                    (bus.Nivel_Descanso == 2'd0) || (bus.Nivel_Medicina == 2'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt <= '0;
            modo_q  <= 1'b0;
        end else if (bus.test) begin
            modo_q  <= ~modo_q;
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_prev    <= 1'b0;
            m_prev    <= 1'b0;
            anim_cnt  <= '0;
            anim_tipo <= COMIENDO;
        end else begin
            e_prev <= bus.senal_5segEnergia;
            m_prev <= bus.senal_5segMedicina;
            if (rise_m) begin
                anim_cnt  <= ANIM_LOAD;
                anim_tipo <= CURANDO;
            end else if (rise_e) begin
                anim_cnt  <= ANIM_LOAD;
                anim_tipo <= COMIENDO;
            end else if (tick && anim_cnt != 4'd0) begin
                anim_cnt <= anim_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        estado_d = NORMAL;
        if (muerto_q)                          estado_d = MUERTO;
        else if (anim_cnt != 4'd0)             estado_d = anim_tipo;
        else if (bus.Nivel_Medicina == 2'd0)   estado_d = ENFERMO;
        else if (bus.Nivel_Energia == 2'd0)    estado_d = HAMBRIENTO;
        else if (bus.Nivel_Descanso == 2'd0)   estado_d = CANSADO;
        else if (bus.Nivel_Animo == 2'd0)      estado_d = TRISTE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crit_cnt <= '0;
            muerto_q <= 1'b0;
            alarma_q <= 1'b0;
            edad_q   <= '0;
            estado_q <= NORMAL;
        end else begin
            if (!crit)
                crit_cnt <= '0;
            else if (tick && crit_cnt != 8'hFF)
                crit_cnt <= crit_cnt + 8'd1;
            if (crit_cnt == MUERTE_CNT)
                muerto_q <= 1'b1;
            if (tick && !muerto_q && edad_q != 8'hFF)
                edad_q <= edad_q + 8'd1;
            alarma_q <= crit && !muerto_q;
            estado_q <= estado_d;
        end
    end

    assign bus.estado    = estado_q;
    assign bus.alarma    = alarma_q;
    assign bus.muerto    = muerto_q;
    assign bus.modo_test = modo_q;
    assign bus.edad      = edad_q;
    assign bus.tick_seg  = tick;

endmodule

// File: tb/tb_estado_mascota.sv
// Directed bench for estado_mascota with a 10-cycle second and 5x test acceleration.
module tb_estado_mascota;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    estado_mascota_if bus();

    estado_mascota #(
        .TICKS_SEG(10),
        .TEST_DIV (5),
        .T_MUERTE (4),
        .T_ANIM   (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves time just after a negedge; the next posedge is edge E1.
    task automatic do_reset();
        reset = 1'b0;
        bus.test = 1'b0;
        bus.Nivel_Animo = 2'd3;
        bus.Nivel_Energia = 2'd3;
        bus.Nivel_Descanso = 2'd3;
        bus.Nivel_Medicina = 2'd3;
        bus.senal_5segEnergia = 1'b0;
        bus.senal_5segMedicina = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        int bad;
        int nticks;
        logic exp_t;
        bad = 0;
        nticks = 0;
        do_reset();
        for (int i = 1; i <= 100; i++) begin
            cyc(1);
            exp_t = ((i % 10) == 9);
            if (bus.tick_seg !== exp_t) bad++;
            if (bus.tick_seg === 1'b1) nticks++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL tick_pattern: wrong cycles=%0d expected 0", bad); end
        checks++; if (nticks !== 10) begin errors++; $display("FAIL tick_count: got %0d expected 10", nticks); end
        checks++; if (bus.edad !== 8'd10) begin errors++; $display("FAIL edad_100: got %0d expected 10", bus.edad); end
        checks++; if (bus.estado !== 3'd0) begin errors++; $display("FAIL estado_normal: got %0d expected 0", bus.estado); end
        checks++; if (bus.alarma !== 1'b0) begin errors++; $display("FAIL alarma_normal: got %0d expected 0", bus.alarma); end
        cyc(3);
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.estado, bus.alarma, bus.muerto, bus.modo_test, bus.edad, bus.tick_seg} !== 15'd0) begin
            errors++;
            $display("FAIL reset_async: got estado=%0d alarma=%0d muerto=%0d modo=%0d edad=%0d tick=%0d expected all 0",
                     bus.estado, bus.alarma, bus.muerto, bus.modo_test, bus.edad, bus.tick_seg);
        end
    endtask

    task automatic test_priority();
        do_reset();
        bus.Nivel_Medicina = 2'd0;
        bus.Nivel_Energia = 2'd0;
        cyc(1);
        checks++; if (bus.estado !== 3'd4) begin errors++; $display("FAIL prio_enfermo: got %0d expected 4", bus.estado); end
        checks++; if (bus.alarma !== 1'b1) begin errors++; $display("FAIL prio_alarma1: got %0d expected 1", bus.alarma); end
        bus.Nivel_Medicina = 2'd1;
        cyc(1);
        checks++; if (bus.estado !== 3'd2) begin errors++; $display("FAIL prio_hambriento: got %0d expected 2", bus.estado); end
        bus.Nivel_Energia = 2'd1;
        bus.Nivel_Descanso = 2'd0;
        cyc(1);
        checks++; if (bus.estado !== 3'd3) begin errors++; $display("FAIL prio_cansado: got %0d expected 3", bus.estado); end
        checks++; if (bus.alarma !== 1'b1) begin errors++; $display("FAIL prio_alarma3: got %0d expected 1", bus.alarma); end
        bus.Nivel_Descanso = 2'd1;
        bus.Nivel_Animo = 2'd0;
        cyc(1);
        checks++; if (bus.estado !== 3'd1) begin errors++; $display("FAIL prio_triste: got %0d expected 1", bus.estado); end
        bus.Nivel_Animo = 2'd3;
        cyc(1);
        checks++; if (bus.estado !== 3'd0) begin errors++; $display("FAIL prio_back_normal: got %0d expected 0", bus.estado); end
        checks++; if (bus.alarma !== 1'b0) begin errors++; $display("FAIL prio_alarma_off: got %0d expected 0", bus.alarma); end
    endtask

    task automatic test_action();
        do_reset();
        bus.senal_5segEnergia = 1'b1;
        cyc(1);                                   // E1
        bus.senal_5segEnergia = 1'b0;
        cyc(1);                                   // E2
        checks++; if (bus.estado !== 3'd5) begin errors++; $display("FAIL anim_comiendo: got %0d expected 5", bus.estado); end
        bus.Nivel_Descanso = 2'd0;
        cyc(28);                                  // E30
        checks++; if (bus.estado !== 3'd5) begin errors++; $display("FAIL anim_hold: got %0d expected 5", bus.estado); end
        cyc(1);                                   // E31
        checks++; if (bus.estado !== 3'd3) begin errors++; $display("FAIL anim_end: got %0d expected 3", bus.estado); end
        bus.Nivel_Descanso = 2'd3;
        bus.senal_5segEnergia = 1'b1;
        bus.senal_5segMedicina = 1'b1;
        cyc(1);                                   // E32
        bus.senal_5segEnergia = 1'b0;
        bus.senal_5segMedicina = 1'b0;
        cyc(1);                                   // E33
        checks++; if (bus.estado !== 3'd6) begin errors++; $display("FAIL anim_both: got %0d expected 6", bus.estado); end
        bus.senal_5segEnergia = 1'b1;
        cyc(1);                                   // E34
        bus.senal_5segEnergia = 1'b0;
        cyc(1);                                   // E35
        checks++; if (bus.estado !== 3'd5) begin errors++; $display("FAIL anim_restart: got %0d expected 5", bus.estado); end
    endtask

    task automatic test_death();
        do_reset();
        bus.Nivel_Animo = 2'd0;
        cyc(40);                                  // E40, crit_cnt = 4
        checks++; if (bus.muerto !== 1'b0) begin errors++; $display("FAIL death_early: got %0d expected 0", bus.muerto); end
        checks++; if (bus.edad !== 8'd4) begin errors++; $display("FAIL death_edad: got %0d expected 4", bus.edad); end
        cyc(1);                                   // E41
        checks++; if (bus.muerto !== 1'b1) begin errors++; $display("FAIL death_flag: got %0d expected 1", bus.muerto); end
        checks++; if (bus.alarma !== 1'b1) begin errors++; $display("FAIL death_alarma_lag: got %0d expected 1", bus.alarma); end
        cyc(1);                                   // E42
        checks++; if (bus.estado !== 3'd7) begin errors++; $display("FAIL death_estado: got %0d expected 7", bus.estado); end
        checks++; if (bus.alarma !== 1'b0) begin errors++; $display("FAIL death_alarma_off: got %0d expected 0", bus.alarma); end
        bus.Nivel_Animo = 2'd3;
        bus.senal_5segMedicina = 1'b1;
        cyc(1);
        bus.senal_5segMedicina = 1'b0;
        cyc(21);                                  // E64
        checks++; if (bus.estado !== 3'd7) begin errors++; $display("FAIL death_frozen: got %0d expected 7", bus.estado); end
        checks++; if (bus.edad !== 8'd4) begin errors++; $display("FAIL death_edad_frozen: got %0d expected 4", bus.edad); end
        checks++; if (bus.muerto !== 1'b1) begin errors++; $display("FAIL death_sticky: got %0d expected 1", bus.muerto); end
        reset = 1'b0;
        #1;
        checks++; if ({bus.muerto, bus.estado} !== 4'd0) begin errors++; $display("FAIL death_revive: got muerto=%0d estado=%0d expected 0 0", bus.muerto, bus.estado); end

        do_reset();
        bus.Nivel_Animo = 2'd0;
        cyc(30);                                  // E30, crit_cnt = 3
        bus.Nivel_Animo = 2'd3;
        cyc(1);                                   // E31, crit_cnt cleared
        bus.Nivel_Animo = 2'd0;
        cyc(14);                                  // E45
        checks++; if (bus.muerto !== 1'b0) begin errors++; $display("FAIL near_death_clear: got %0d expected 0", bus.muerto); end
        cyc(25);                                  // E70
        checks++; if (bus.muerto !== 1'b0) begin errors++; $display("FAIL near_death_e70: got %0d expected 0", bus.muerto); end
        cyc(1);                                   // E71
        checks++; if (bus.muerto !== 1'b1) begin errors++; $display("FAIL near_death_e71: got %0d expected 1", bus.muerto); end
    endtask

    task automatic test_mode();
        int bad;
        logic exp_t;
        bad = 0;
        do_reset();
        bus.test = 1'b1;
        cyc(1);                                   // E1
        bus.test = 1'b0;
        #1;
        checks++; if (bus.modo_test !== 1'b1) begin errors++; $display("FAIL mode_on: got %0d expected 1", bus.modo_test); end
        if (bus.tick_seg !== 1'b0) bad++;
        for (int i = 2; i <= 10; i++) begin
            cyc(1);
            exp_t = ((i % 2) == 0);
            if (bus.tick_seg !== exp_t) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL mode_tick_pattern: wrong cycles=%0d expected 0", bad); end
        checks++; if (bus.edad !== 8'd4) begin errors++; $display("FAIL mode_edad: got %0d expected 4", bus.edad); end
        bus.test = 1'b1;
        #1;
        checks++; if (bus.tick_seg !== 1'b0) begin errors++; $display("FAIL mode_tick_suppress: got %0d expected 0", bus.tick_seg); end
        cyc(1);                                   // E11
        bus.test = 1'b0;
        checks++; if (bus.modo_test !== 1'b0) begin errors++; $display("FAIL mode_off: got %0d expected 0", bus.modo_test); end
        checks++; if (bus.edad !== 8'd4) begin errors++; $display("FAIL mode_edad_hold: got %0d expected 4", bus.edad); end
        cyc(8);                                   // E19
        checks++; if (bus.tick_seg !== 1'b0) begin errors++; $display("FAIL mode_tick_e19: got %0d expected 0", bus.tick_seg); end
        cyc(1);                                   // E20
        checks++; if (bus.tick_seg !== 1'b1) begin errors++; $display("FAIL mode_tick_e20: got %0d expected 1", bus.tick_seg); end
        cyc(1);                                   // E21
        checks++; if (bus.edad !== 8'd5) begin errors++; $display("FAIL mode_edad_e21: got %0d expected 5", bus.edad); end

        do_reset();
        bus.test = 1'b1;
        bus.Nivel_Animo = 2'd0;
        cyc(1);                                   // E1
        bus.test = 1'b0;
        cyc(8);                                   // E9, crit_cnt = 4
        checks++; if (bus.muerto !== 1'b0) begin errors++; $display("FAIL mode_death_e9: got %0d expected 0", bus.muerto); end
        cyc(1);                                   // E10
        checks++; if (bus.muerto !== 1'b1) begin errors++; $display("FAIL mode_death_e10: got %0d expected 1", bus.muerto); end
    endtask

    task automatic test_saturation();
        do_reset();
        bus.test = 1'b1;
        cyc(1);                                   // E1
        bus.test = 1'b0;
        cyc(508);                                 // E509
        checks++; if (bus.edad !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d expected 254", bus.edad); end
        cyc(2);                                   // E511
        checks++; if (bus.edad !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d expected 255", bus.edad); end
        cyc(100);
        checks++; if (bus.edad !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d expected 255", bus.edad); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cyc(9);                                   // E9
        checks++; if (bus.tick_seg !== 1'b1) begin errors++; $display("FAIL b2b_tick_e9: got %0d expected 1", bus.tick_seg); end
        bus.test = 1'b1;
        #1;
        checks++; if (bus.tick_seg !== 1'b0) begin errors++; $display("FAIL b2b_suppress: got %0d expected 0", bus.tick_seg); end
        cyc(1);                                   // E10
        bus.test = 1'b0;
        checks++; if (bus.modo_test !== 1'b1) begin errors++; $display("FAIL b2b_mode: got %0d expected 1", bus.modo_test); end
        checks++; if (bus.edad !== 8'd0) begin errors++; $display("FAIL b2b_edad0: got %0d expected 0", bus.edad); end
        cyc(1);                                   // E11
        checks++; if (bus.tick_seg !== 1'b1) begin errors++; $display("FAIL b2b_tick_e11: got %0d expected 1", bus.tick_seg); end
        cyc(1);                                   // E12
        checks++; if (bus.edad !== 8'd1) begin errors++; $display("FAIL b2b_edad1: got %0d expected 1", bus.edad); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b0;
        test_reset();
        test_priority();
        test_action();
        test_death();
        test_mode();
        test_saturation();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/estado_mascota.md
Name: estado_mascota

Overview:
- Downstream of the needs-level stage. Consumes the four 2-bit need levels (Animo, Energia, Descanso, Medicina) and the Energia/Medicina 5-second action pulses.
- Produces the pet's global state code for the display, a critical-need alarm, a sticky death flag and an age counter.
- Owns the seconds prescaler. Owns test mode, which accelerates the prescaler.

Parameters:
- TICKS_SEG, 50_000_000: clk cycles per second in normal mode.
- TEST_DIV, 10: time-acceleration factor in test mode; prescaler period becomes TICKS_SEG/TEST_DIV.
- T_MUERTE, 30: consecutive seconds with any level at 0 before death (1..255).
- T_ANIM, 3: seconds the COMIENDO/CURANDO states are shown (1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- test  in  1  debounced one-cycle pulse; toggles test mode
- Nivel_Animo  in  2  0 = critical, 3 = full
- Nivel_Energia  in  2  same encoding
- Nivel_Descanso  in  2  same encoding
- Nivel_Medicina  in  2  same encoding
- senal_5segEnergia  in  1  feeding action indicator, level or pulse
- senal_5segMedicina  in  1  medicine action indicator, level or pulse
- estado  out  3  0 NORMAL, 1 TRISTE, 2 HAMBRIENTO, 3 CANSADO, 4 ENFERMO, 5 COMIENDO, 6 CURANDO, 7 MUERTO
- alarma  out  1  a need is critical and the pet is alive
- muerto  out  1  sticky death flag
- modo_test  out  1  test mode active
- edad  out  8  seconds alive, saturating
- tick_seg  out  1  one-cycle pulse per (scaled) second

Behaviour:
- Reset (reset = 0, asynchronous): all registers clear immediately; all outputs are 0 (estado = NORMAL). Reset mid-operation, including while MUERTO, fully revives the pet.
- All inputs are synchronous to clk. No input synchronisers.

Prescaler:
- Counts 0..P-1. P = TICKS_SEG, or TICKS_SEG/TEST_DIV when modo_test = 1.
- tick_seg is high for exactly the cycle the counter is at P-1; the counter then returns to 0.

Test mode:
- A test pulse toggles modo_test on the next edge and clears the prescaler to 0.
- No tick is generated in that cycle. The first tick after a toggle arrives P cycles later.

Action detection:
- Rising edges of senal_5segEnergia and senal_5segMedicina are detected with 1-cycle registered history.
- An edge loads anim_cnt = T_ANIM and anim_tipo (Energia → COMIENDO, Medicina → CURANDO).
- Both edges in the same cycle: CURANDO wins.
- A new edge during an animation restarts it with the new type.
- anim_cnt decrements on tick_seg and stops at 0.

Critical counter:
- crit = any level == 0.
- crit_cnt (8 bits) increments on tick_seg while crit is true, saturating at 255.
- It clears to 0 on any cycle where crit is false.
- When crit_cnt == T_MUERTE, muerto is set on the next edge. muerto stays set until reset.

State selection:
- estado is registered: the value is computed from the current-cycle inputs and counters and appears one cycle later. Priority, first match wins:
  1. muerto → MUERTO
  2. anim_cnt ≠ 0 → anim_tipo
  3. Medicina == 0 → ENFERMO
  4. Energia == 0 → HAMBRIENTO
  5. Descanso == 0 → CANSADO
  6. Animo == 0 → TRISTE
  7. otherwise NORMAL
- Once muerto is set, estado is frozen at MUERTO. Action edges and level changes are ignored, although anim_cnt may still update internally.

Other outputs:
- alarma is registered: crit AND NOT muerto. It falls on the cycle after death.
- edad increments on tick_seg while muerto = 0, saturating at 255, and freezes at death.
- The test toggle does not affect crit_cnt, edad or anim_cnt values; only their rate changes.

Test Plan:
Bench parameters: TICKS_SEG = 10, TEST_DIV = 5, T_MUERTE = 4, T_ANIM = 3.
1. Reset then all levels = 3 for 100 cycles → estado = 0, alarma = 0; tick_seg every 10 cycles; edad = 10. Assert reset mid-count → all outputs 0 immediately.
2. Priority: Medicina = 0 with Energia = 0 → estado = 4 one cycle later. Raise Medicina to 1 → estado = 2. Energia = 1, Descanso = 0 → 3. Descanso = 1, Animo = 0 → 1. alarma = 1 throughout.
3. Action: one-cycle senal_5segEnergia pulse → estado = 5 for 3 ticks (about 30 cycles), then the level-derived state returns. Simultaneous Energia and Medicina edges → estado = 6.
4. Death: Animo = 0 held → muerto = 1 and estado = 7 after 4 ticks. alarma falls, edad freezes. Restore levels to 3 and pulse senal_5segMedicina → estado stays 7 until reset. Also: restore a level at tick 3 → crit_cnt clears, no death.
5. Test mode: test pulse → modo_test = 1, prescaler cleared, tick_seg every 2 cycles. A second pulse → modo_test = 0, period back to 10. Death in test mode occurs after 8 cycles of criticality.
6. Saturation: run 300 ticks alive → edad holds at 255. Test pulse on the same cycle as a tick → no tick that cycle, the next tick arrives after the new period.
